led_chaser: RTL and testbench
=============================

LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 Parameter WIDTH, default 16: LED count; legal range 2..32.
REQ-002 Parameter CNT_W, default 32: width of the step-period counter and of the period input.
REQ-003 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port en, input, 1: 1 = run, 0 = freeze counter and pattern.
REQ-006 Port mode, input, 2: 0 ROTL, 1 ROTR, 2 BOUNCE, 3 FILL.
REQ-007 Port period, input, CNT_W: the pattern advances once every period+1 enabled cycles.
REQ-008 Port led, output, WIDTH: current pattern, registered.
REQ-009 Port step, output, 1: one-cycle pulse in the cycle the pattern advances.
REQ-010 Port wrap, output, 1: one-cycle pulse when a step completes a full pattern cycle.

Function
REQ-011 Seed pattern SHALL be 1 (bit 0 lit, all others dark) for every mode.
REQ-012 Counter: if en=1 and count >= period, the block SHALL step and set count to 0; if en=1 otherwise, count increments; if en=0, count holds.
REQ-013 Because the compare is >=, lowering period below the current count SHALL cause a step on the next enabled cycle; period=0 SHALL step every enabled cycle.
REQ-014 step and wrap SHALL be registered; they are high in the same cycle that led shows the new pattern; both are 0 when en=0.
REQ-015 ROTL: led <= {led[WIDTH-2:0], led[WIDTH-1]}; wrap SHALL pulse when the lit bit moves from WIDTH-1 to 0.
REQ-016 ROTR: led <= {led[0], led[WIDTH-1:1]}; wrap SHALL pulse when the lit bit moves from 0 to WIDTH-1.
REQ-017 BOUNCE uses a direction FSM with states UP and DOWN.
REQ-018 BOUNCE in UP: shift left; on reaching bit WIDTH-1, go to DOWN.
REQ-019 BOUNCE in DOWN: shift right; on reaching bit 0, go to UP and pulse wrap.
REQ-020 BOUNCE has no dwell at either end.
REQ-021 FILL uses a phase FSM with states FILLING and EMPTY.
REQ-022 FILL in FILLING: led <= {led[WIDTH-2:0],1'b1}; once all ones, the next step SHALL set led to 0, go to EMPTY and pulse wrap.
REQ-023 FILL in EMPTY: the next step SHALL set led to 1 and go to FILLING.
REQ-024 Mode change: mode is registered into mode_q each cycle.
REQ-025 When mode != mode_q, the next cycle SHALL load the seed, clear count, set dir=UP and phase=FILLING, and keep step=wrap=0.
REQ-026 The mode-change reseed SHALL take priority over stepping and SHALL apply even when en=0.
REQ-027 Simultaneous mode change and count>=period: the reseed wins; no step is emitted.
REQ-028 Count SHALL never overflow; period = all ones SHALL be legal, and a step still occurs at count = 2^CNT_W-1.

Reset
REQ-029 During rst=1 the block SHALL set led=1, count=0, step=0, wrap=0, dir=UP, phase=FILLING and mode_q=mode.
REQ-030 Because mode_q=mode at reset, no spurious reseed SHALL follow reset.
REQ-031 Reset mid-operation SHALL override en, mode change and a pending step in the same cycle.
REQ-032 The first step after reset SHALL occur period+1 enabled cycles after rst falls.

Structure
REQ-033 Package led_pkg SHALL hold the mode encodings (MODE_ROTL..MODE_FILL) and the BOUNCE/FILL state encodings.
REQ-034 The period counter and step strobe SHALL live in one sub-module, tick_div (inputs clk, rst, en, clr, period; output tick), where clr is the mode-change reseed.
REQ-035 The pattern register and the mode FSMs SHALL live in led_chaser.

Verification
REQ-036 Reset release, WIDTH=16, mode=0, period=5, en=1 -> step every 6 cycles; led 0x0001, 0x0002, ...; wrap on step 16 when led goes 0x8000 -> 0x0001.
REQ-037 mode=2, period=0 -> led walks 0x0001 up to 0x8000 then back down; wrap on the 30th step when led returns to 0x0001; no repeated values at the ends.
REQ-038 mode=3, period=0 -> 0x0001, 0x0003, ..., 0xFFFF, 0x0000 (wrap), then 0x0001.
REQ-039 Mode 0 -> 1 switch with count=4, period=5 -> next cycle led=0x0001, count=0, step=0; the following step occurs 6 cycles later and gives led=0x8000.
REQ-040 en=0 for 10 cycles mid-count, then period lowered from 9 to 2 while count=7 -> led and count frozen with no pulses while en=0; a step on the first cycle after en=1.
REQ-041 rst asserted on the same cycle as a due step -> led=0x0001, step=0, wrap=0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the LED chaser: pattern modes and the BOUNCE/FILL state machines.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'd0,
    MODE_ROTR   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    PH_FILLING = 1'b0,
    PH_EMPTY   = 1'b1
  } phase_e;

endpackage

// File: rtl/led_chaser_tick_div.sv
// Step-period divider: raises tick on every (period+1)-th enabled cycle.
// A clear restarts the count and suppresses that cycle's tick.
module tick_div #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] r_count;
  logic             w_due;

  // >= compare lets a lowered period fire immediately and caps count at all-ones.
  assign w_due = (r_count >= period);
  assign tick  = en & ~clr & w_due;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_due ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_chaser.sv
// LED chaser top: pattern register, per-mode stepping and the BOUNCE/FILL FSMs.
// A mode change reseeds the pattern on the following edge, even while disabled.
module led_chaser
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] SEED = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [1:0]       r_mode_q;
  dir_e             r_dir;
  phase_e           r_phase;
  logic [WIDTH-1:0] r_led;
  logic             r_step;
  logic             r_wrap;
  logic             w_reseed;
  logic             w_tick;

  assign w_reseed = (mode != r_mode_q);
  assign led      = r_led;
  assign step     = r_step;
  assign wrap     = r_wrap;

  tick_div #(.CNT_W(CNT_W)) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (w_reseed),
    .period (period),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    r_mode_q <= mode;
    if (rst || w_reseed) begin
      r_led   <= SEED;
      r_dir   <= DIR_UP;
      r_phase <= PH_FILLING;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_step <= w_tick;
      r_wrap <= 1'b0;
      if (w_tick) begin
        case (mode_e'(r_mode_q))
          MODE_ROTL: begin
            r_led  <= {r_led[WIDTH-2:0], r_led[WIDTH-1]};
            r_wrap <= r_led[WIDTH-1];
          end
          MODE_ROTR: begin
            r_led  <= {r_led[0], r_led[WIDTH-1:1]};
            r_wrap <= r_led[0];
          end
          MODE_BOUNCE: begin
            // Direction flips on the step that lands on an end bit, so ends never dwell.
            if (r_dir == DIR_UP) begin
              r_led <= r_led << 1;
              if (r_led[WIDTH-2]) r_dir <= DIR_DOWN;
            end else begin
              r_led <= r_led >> 1;
              if (r_led[1]) begin
                r_dir  <= DIR_UP;
                r_wrap <= 1'b1;
              end
            end
          end
          MODE_FILL: begin
            if (r_phase == PH_FILLING) begin
              if (r_led == ONES) begin
                r_led   <= '0;
                r_phase <= PH_EMPTY;
                r_wrap  <= 1'b1;
              end else begin
                r_led <= {r_led[WIDTH-2:0], 1'b1};
              end
            end else begin
              r_led   <= SEED;
              r_phase <= PH_FILLING;
            end
          end
          default: r_led <= SEED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser: directed scenarios then random traffic vs. a position-index model.
module tb_led_chaser;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] period = 32'd5;
  logic [W-1:0] led;
  logic        step;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  // Model: k indexes the position within one full pattern cycle of the current mode.
  int          k = 0;
  logic [31:0] m_cnt = 0;
  logic [1:0]  m_mq = 2'd0;
  logic        m_step = 1'b0;
  logic        m_wrap = 1'b0;
  logic [W-1:0] m_led = 16'h0001;

  led_chaser #(.WIDTH(W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period),
    .led(led), .step(step), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int plen(input logic [1:0] md);
    case (md)
      2'd2:    return 2 * W - 2;
      2'd3:    return W + 1;
      default: return W;
    endcase
  endfunction

  function automatic logic wrap_at(input logic [1:0] md, input int kk);
    case (md)
      2'd1:    return kk == 1;
      2'd3:    return kk == W;
      default: return kk == 0;
    endcase
  endfunction

  function automatic logic [W-1:0] pat(input logic [1:0] md, input int kk);
    longint v;
    case (md)
      2'd0:    v = longint'(1) << kk;
      2'd1:    v = longint'(1) << ((W - kk) % W);
      2'd2:    v = longint'(1) << ((kk < W) ? kk : (2 * W - 2 - kk));
      default: v = (kk < W) ? ((longint'(1) << (kk + 1)) - 1) : 0;
    endcase
    return W'(v);
  endfunction

  task automatic model_edge();
    if (rst || mode != m_mq) begin
      k = 0; m_cnt = 0; m_step = 1'b0; m_wrap = 1'b0;
    end else if (en && m_cnt >= period) begin
      m_cnt = 0;
      k = (k + 1) % plen(m_mq);
      m_step = 1'b1;
      m_wrap = wrap_at(m_mq, k);
    end else begin
      if (en) m_cnt = m_cnt + 1;
      m_step = 1'b0; m_wrap = 1'b0;
    end
    m_mq = mode;
    m_led = pat(m_mq, k);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the pre-edge inputs, then compare after the edge.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("led", 32'(led), 32'(m_led));
    chk("step", 32'(step), 32'(m_step));
    chk("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic run_to_wrap(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (step) n++;
      if (wrap) break;
    end
  endtask

  initial begin
    int n;
    // Reset, then ROTL with period 5.
    cyc(); cyc();
    chk("reset_led", 32'(led), 32'h0001);
    chk("reset_step", 32'(step), 32'h0);
    rst = 1'b0; en = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (step) n++;
    end
    chk("first_step_latency", 32'(n), 32'd1);
    chk("first_step_led", 32'(led), 32'h0002);
    run_to_wrap(200, n);
    chk("rotl_wrap_step", 32'(n + 1), 32'd16);
    chk("rotl_wrap_led", 32'(led), 32'h0001);

    // BOUNCE, period 0.
    mode = 2'd2; period = 0;
    cyc();
    run_to_wrap(60, n);
    chk("bounce_wrap_step", 32'(n), 32'd30);
    chk("bounce_wrap_led", 32'(led), 32'h0001);

    // FILL, period 0.
    mode = 2'd3;
    cyc();
    run_to_wrap(40, n);
    chk("fill_wrap_step", 32'(n), 32'd16);
    chk("fill_wrap_led", 32'(led), 32'h0000);
    cyc();
    chk("fill_refill_led", 32'(led), 32'h0001);

    // Mode switch with count=4, period=5.
    mode = 2'd0; period = 5;
    cyc();
    for (int i = 0; i < 4; i++) cyc();
    mode = 2'd1;
    cyc();
    chk("switch_led", 32'(led), 32'h0001);
    chk("switch_step", 32'(step), 32'h0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n++;
      if (step) break;
    end
    chk("switch_step_delay", 32'(n), 32'd6);
    chk("switch_step_led", 32'(led), 32'h8000);

    // Freeze, then lower period below count.
    period = 9;
    for (int i = 0; i < 7; i++) cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    period = 2; en = 1'b1;
    cyc();
    chk("lowered_period_step", 32'(step), 32'h1);

    // Reset on a due step.
    period = 3;
    for (int i = 0; i < 3; i++) cyc();
    rst = 1'b1;
    cyc();
    chk("rst_due_led", 32'(led), 32'h0001);
    chk("rst_due_step", 32'(step), 32'h0);
    chk("rst_due_wrap", 32'(wrap), 32'h0);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 150) == 0;
      en  = ($urandom % 8) != 0;
      if (($urandom % 40) == 0) mode = 2'($urandom % 4);
      if (($urandom % 25) == 0)
        period = (($urandom % 10) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
